// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, types and state encoding for the FFT sequencer
package fft_pkg;

   localparam int L_DEF   = 9;
   localparam int N_DEF   = 1 << L_DEF;
   localparam int LAT_DEF = 3;

   typedef logic [L_DEF-1:0] addr_t;
   typedef logic [L_DEF-2:0] tw_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      COMPUTE = 3'd2,
      DRAIN   = 3'd3,
      DONE    = 3'd4
   } ctrl_state_t;

endpackage

// File: rtl/fft_ctrl_if.sv
// rtl/fft_ctrl_if.sv - sample-load, butterfly address and status bundle of the FFT sequencer
interface fft_ctrl_if #(
   parameter int L = fft_pkg::L_DEF
);
   logic         start;
   logic         in_valid;
   logic         in_ready;
   logic         load_we;
   logic [L-1:0] load_addr;
   logic         rd_en;
   logic [L-1:0] rd_addr_a;
   logic [L-1:0] rd_addr_b;
   logic [L-2:0] tw_addr;
   logic         wr_en;
   logic [L-1:0] wr_addr_a;
   logic [L-1:0] wr_addr_b;
   logic         busy;
   logic         done;

   modport master (
      input  start, in_valid,
      output in_ready, load_we, load_addr,
      output rd_en, rd_addr_a, rd_addr_b, tw_addr,
      output wr_en, wr_addr_a, wr_addr_b,
      output busy, done
   );

   modport slave (
      output start, in_valid,
      input  in_ready, load_we, load_addr,
      input  rd_en, rd_addr_a, rd_addr_b, tw_addr,
      input  wr_en, wr_addr_a, wr_addr_b,
      input  busy, done
   );
endinterface

// File: rtl/fft_addr_gen.sv
// rtl/fft_addr_gen.sv - radix-2 DIT butterfly operand and twiddle addresses from stage s and index k
module fft_addr_gen #(
   parameter int L  = 9,
   parameter int SW = 4
) (
   input  logic [SW-1:0] i_s,
   input  logic [L-2:0]  i_k,
   output logic [L-1:0]  o_rd_addr_a,
   output logic [L-1:0]  o_rd_addr_b,
   output logic [L-2:0]  o_tw_addr
);
   localparam logic [SW-1:0] S_MAX = SW'(L - 1);

   logic [L-1:0]  w_k_ext;
   logic [L-1:0]  w_half;
   logic [L-1:0]  w_pos;
   logic [L-1:0]  w_grp;
   logic [L-1:0]  w_a;
   logic [SW-1:0] w_tw_sh;

   assign w_k_ext = {1'b0, i_k};
   assign w_half  = {{(L-1){1'b0}}, 1'b1} << i_s;
   assign w_pos   = w_k_ext & (w_half - 1'b1);
   assign w_grp   = w_k_ext >> i_s;
   // Two-step shift so s+1 cannot wrap the narrow stage width.
   assign w_a     = ((w_grp << i_s) << 1) | w_pos;
   assign w_tw_sh = S_MAX - i_s;

   assign o_rd_addr_a = w_a;
   assign o_rd_addr_b = w_a + w_half;
   // pos < 2^s <= 2^(L-1), so its top bit is always clear here.
   assign o_tw_addr   = w_pos[L-2:0] << w_tw_sh;
endmodule

// File: rtl/reindex_bits.sv
// rtl/reindex_bits.sv - combinational bit-order reversal of a W-bit index
module reindex_bits #(
   parameter int W = 8
) (
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_data
);
   always_comb begin
      o_data = '0;
      for (int i = 0; i < W; i++) begin
         o_data[i] = i_data[W-1-i];
      end
   end
endmodule

// File: rtl/fft_ctrl.sv
// rtl/fft_ctrl.sv - in-place radix-2 DIT FFT sequencer: bit-reversed load, staged butterflies, write-back delay
module fft_ctrl
   import fft_pkg::*;
#(
   parameter int L   = L_DEF,
   parameter int LAT = LAT_DEF
) (
   input  logic       clk,
   input  logic       reset_n,
   fft_ctrl_if.master bus
);
   localparam int SW = $clog2(L);
   localparam int DW = 2 * L + 1;
   localparam logic [SW-1:0] S_LAST = SW'(L - 1);
   localparam logic [2:0]    D_LAST = 3'(LAT - 1);

   ctrl_state_t   r_state;
   ctrl_state_t   w_next;
   logic [L-1:0]  r_cnt;
   logic [L-2:0]  r_k;
   logic [SW-1:0] r_s;
   logic [2:0]    r_drain;
   logic [DW-1:0] r_dly [LAT];

   logic          w_in_ready;
   logic          w_load_we;
   logic          w_load_last;
   logic          w_rd_en;
   logic [L-1:0]  w_rev;
   logic [L-1:0]  w_gen_a;
   logic [L-1:0]  w_gen_b;
   logic [L-2:0]  w_gen_tw;
   logic [L-1:0]  w_rd_a;
   logic [L-1:0]  w_rd_b;

   reindex_bits #(.W(L)) u_rev (
      .i_data (r_cnt),
      .o_data (w_rev)
   );

   fft_addr_gen #(.L(L), .SW(SW)) u_addr (
      .i_s         (r_s),
      .i_k         (r_k),
      .o_rd_addr_a (w_gen_a),
      .o_rd_addr_b (w_gen_b),
      .o_tw_addr   (w_gen_tw)
   );

   assign w_in_ready  = (r_state == LOAD);
   assign w_load_we   = bus.in_valid & w_in_ready;
   assign w_load_last = w_load_we && (r_cnt == '1);
   assign w_rd_en     = (r_state == COMPUTE);
   assign w_rd_a      = w_rd_en ? w_gen_a : '0;
   assign w_rd_b      = w_rd_en ? w_gen_b : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_next = LOAD;
         LOAD:    if (w_load_last) w_next = COMPUTE;
         COMPUTE: if (r_k == '1) w_next = DRAIN;
         DRAIN: begin
            if (r_drain == D_LAST) begin
               w_next = (r_s == S_LAST) ? DONE : COMPUTE;
            end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= '0;
         r_k     <= '0;
         r_s     <= '0;
         r_drain <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) r_cnt <= '0;
            end
            LOAD: begin
               if (w_load_we) r_cnt <= r_cnt + 1'b1;
               if (w_load_last) begin
                  r_s <= '0;
                  r_k <= '0;
               end
            end
            COMPUTE: begin
               r_k     <= r_k + 1'b1;
               r_drain <= '0;
            end
            DRAIN: begin
               r_drain <= r_drain + 1'b1;
               if (r_drain == D_LAST && r_s != S_LAST) begin
                  r_s <= r_s + 1'b1;
                  r_k <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Write-back strobe and addresses trail the read side by the RAM-plus-butterfly latency.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < LAT; i++) r_dly[i] <= '0;
      end else begin
         r_dly[0] <= {w_rd_en, w_rd_a, w_rd_b};
         for (int i = 1; i < LAT; i++) r_dly[i] <= r_dly[i-1];
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.load_we   = w_load_we;
   assign bus.load_addr = w_in_ready ? w_rev : '0;
   assign bus.rd_en     = w_rd_en;
   assign bus.rd_addr_a = w_rd_a;
   assign bus.rd_addr_b = w_rd_b;
   assign bus.tw_addr   = w_rd_en ? w_gen_tw : '0;
   assign bus.wr_en     = r_dly[LAT-1][DW-1];
   assign bus.wr_addr_a = r_dly[LAT-1][2*L-1:L];
   assign bus.wr_addr_b = r_dly[LAT-1][L-1:0];
   assign bus.busy      = (r_state != IDLE);
   assign bus.done      = (r_state == DONE);
endmodule

// File: tb/tb_fft_ctrl.sv
// tb/tb_fft_ctrl.sv - directed check of load order, stage addressing, write-back delay and reset for L=3, LAT=2
module tb_fft_ctrl;
   localparam int L   = 3;
   localparam int LAT = 2;
   localparam int T   = 20;

   logic clk;
   logic reset_n;
   int   n_chk;
   int   n_pass;

   int load_exp [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
   int tab_a    [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
   int tab_b    [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
   int tab_tw   [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
   int e_en [T];
   int e_a  [T];
   int e_b  [T];
   int e_tw [T];

   fft_ctrl_if #(.L(L)) bus ();

   fft_ctrl #(.L(L), .LAT(LAT)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic load_frame(input bit gap);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("in_ready", 32'(bus.in_ready), 1);
      for (int i = 0; i < 8; i++) begin
         if (gap && i == 3) begin
            bus.in_valid = 1'b0;
            #1;
            chk("gap_we", 32'(bus.load_we), 0);
            chk("gap_addr", 32'(bus.load_addr), 6);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            chk("gap_we2", 32'(bus.load_we), 0);
            chk("gap_addr2", 32'(bus.load_addr), 6);
            @(negedge clk);
         end
         bus.in_valid = 1'b1;
         #1;
         chk("load_we", 32'(bus.load_we), 1);
         chk("load_addr", 32'(bus.load_addr), 32'(load_exp[i]));
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic compute_frame(input bit hold_start);
      for (int t = 0; t < T; t++) begin
         chk("rd_en", 32'(bus.rd_en), 32'(e_en[t]));
         if (e_en[t] == 1) begin
            chk("rd_a", 32'(bus.rd_addr_a), 32'(e_a[t]));
            chk("rd_b", 32'(bus.rd_addr_b), 32'(e_b[t]));
            chk("tw", 32'(bus.tw_addr), 32'(e_tw[t]));
         end
         if (t >= LAT) begin
            chk("wr_en", 32'(bus.wr_en), 32'(e_en[t-LAT]));
            if (e_en[t-LAT] == 1) begin
               chk("wr_a", 32'(bus.wr_addr_a), 32'(e_a[t-LAT]));
               chk("wr_b", 32'(bus.wr_addr_b), 32'(e_b[t-LAT]));
            end
         end else begin
            chk("wr_en_lead", 32'(bus.wr_en), 0);
         end
         chk("done", 32'(bus.done), (t == 18) ? 1 : 0);
         chk("busy", 32'(bus.busy), (t == 19) ? 0 : 1);
         if (t == 4) bus.start = 1'b1;
         if (t == 5) bus.start = 1'b0;
         if (t == 18 && hold_start) bus.start = 1'b1;
         @(negedge clk);
      end
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      for (int t = 0; t < T; t++) begin
         e_en[t] = 0; e_a[t] = 0; e_b[t] = 0; e_tw[t] = 0;
      end
      for (int s = 0; s < 3; s++) begin
         for (int j = 0; j < 4; j++) begin
            e_en[s*6+j] = 1;
            e_a[s*6+j]  = tab_a[s*4+j];
            e_b[s*6+j]  = tab_b[s*4+j];
            e_tw[s*6+j] = tab_tw[s*4+j];
         end
      end

      reset_n = 1'b0;
      bus.start = 1'b1;
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      bus.start = 1'b0;
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_ready", 32'(bus.in_ready), 0);
      chk("rst_rd_en", 32'(bus.rd_en), 0);
      chk("rst_wr_en", 32'(bus.wr_en), 0);
      chk("rst_done", 32'(bus.done), 0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", 32'(bus.busy), 0);

      load_frame(1'b1);
      compute_frame(1'b1);
      chk("start_hold_idle", 32'(bus.start), 1);

      load_frame(1'b0);
      compute_frame(1'b0);

      load_frame(1'b0);
      repeat (3) @(negedge clk);
      chk("mid_rd_en", 32'(bus.rd_en), 1);
      reset_n = 1'b0;
      #1;
      chk("mrst_busy", 32'(bus.busy), 0);
      chk("mrst_rd_en", 32'(bus.rd_en), 0);
      chk("mrst_rd_a", 32'(bus.rd_addr_a), 0);
      chk("mrst_wr_en", 32'(bus.wr_en), 0);
      chk("mrst_ready", 32'(bus.in_ready), 0);
      chk("mrst_done", 32'(bus.done), 0);
      @(negedge clk);
      reset_n = 1'b1;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("post_wr_en", 32'(bus.wr_en), 0);
         chk("post_load_we", 32'(bus.load_we), 0);
         chk("post_busy", 32'(bus.busy), 0);
      end
      bus.in_valid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
